// File: rtl/placar_loteria.sv
// Scoreboard for a two-player lottery match: accumulates per-round points and
// prize values over NUM_RODADAS rounds, then holds the winner until a new match.
module placar_loteria #(
  parameter int NUM_RODADAS     = 5,
  parameter int PREMIO_MAX_ACUM = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       resultado_valido,
  input  logic [1:0] premio,
  input  logic [4:0] p1,
  input  logic [4:0] p2,
  input  logic       novo_jogo,
  output logic [7:0] total_p1,
  output logic [7:0] total_p2,
  output logic [3:0] rodada,
  output logic [7:0] cont_premios,
  output logic       pronto,
  output logic [1:0] vencedor,
  output logic       campeao_valido
);

  typedef enum logic [1:0] {OCIOSO, ACUMULA, COMPARA, CAMPEAO} estado_t;

  localparam logic [3:0] ULTIMA_RODADA = 4'(NUM_RODADAS);
  localparam logic [8:0] TETO          = 9'(PREMIO_MAX_ACUM);

  // Nine-bit sum so the carry is visible before clamping to the ceiling.
  function automatic logic [7:0] soma_sat(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > TETO) ? TETO[7:0] : s[7:0];
  endfunction

  function automatic logic [7:0] valor_premio(input logic [1:0] codigo);
    case (codigo)
      2'd1:    return 8'd1;
      2'd2:    return 8'd2;
      2'd3:    return 8'd5;
      default: return 8'd0;
    endcase
  endfunction

  estado_t    estado_q, estado_d;
  logic [1:0] premio_q, premio_d;
  logic [4:0] p1_q, p1_d;
  logic [4:0] p2_q, p2_d;
  logic [7:0] total_p1_q, total_p1_d;
  logic [7:0] total_p2_q, total_p2_d;
  logic [3:0] rodada_q, rodada_d;
  logic [7:0] cont_premios_q, cont_premios_d;
  logic [1:0] vencedor_q, vencedor_d;
  logic       campeao_valido_q, campeao_valido_d;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    estado_d         = estado_q;
    premio_d         = premio_q;
    p1_d             = p1_q;
    p2_d             = p2_q;
    total_p1_d       = total_p1_q;
    total_p2_d       = total_p2_q;
    rodada_d         = rodada_q;
    cont_premios_d   = cont_premios_q;
    vencedor_d       = vencedor_q;
    campeao_valido_d = campeao_valido_q;

    if (novo_jogo) begin
      estado_d         = OCIOSO;
      total_p1_d       = '0;
      total_p2_d       = '0;
      rodada_d         = '0;
      cont_premios_d   = '0;
      vencedor_d       = '0;
      campeao_valido_d = 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (resultado_valido) begin
            premio_d = premio;
            p1_d     = p1;
            p2_d     = p2;
            estado_d = ACUMULA;
          end
        end
        ACUMULA: begin
          total_p1_d     = soma_sat(total_p1_q, {3'b000, p1_q});
          total_p2_d     = soma_sat(total_p2_q, {3'b000, p2_q});
          cont_premios_d = soma_sat(cont_premios_q, valor_premio(premio_q));
          rodada_d       = rodada_q + 4'd1;
          estado_d       = (rodada_d == ULTIMA_RODADA) ? COMPARA : OCIOSO;
        end
        COMPARA: begin
          if (total_p1_q > total_p2_q)      vencedor_d = 2'd1;
          else if (total_p2_q > total_p1_q) vencedor_d = 2'd2;
          else                              vencedor_d = 2'd3;
          estado_d = CAMPEAO;
        end
        CAMPEAO: begin
          // Valid flag follows one edge behind the winner so it never leads it.
          campeao_valido_d = 1'b1;
        end
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!reset) begin
      estado_q         <= OCIOSO;
      premio_q         <= '0;
      p1_q             <= '0;
      p2_q             <= '0;
      total_p1_q       <= '0;
      total_p2_q       <= '0;
      rodada_q         <= '0;
      cont_premios_q   <= '0;
      vencedor_q       <= '0;
      campeao_valido_q <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      premio_q         <= premio_d;
      p1_q             <= p1_d;
      p2_q             <= p2_d;
      total_p1_q       <= total_p1_d;
      total_p2_q       <= total_p2_d;
      rodada_q         <= rodada_d;
      cont_premios_q   <= cont_premios_d;
      vencedor_q       <= vencedor_d;
      campeao_valido_q <= campeao_valido_d;
    end
  end

  assign total_p1       = total_p1_q;
  assign total_p2       = total_p2_q;
  assign rodada         = rodada_q;
  assign cont_premios   = cont_premios_q;
  assign pronto         = (estado_q == OCIOSO);
  assign vencedor       = vencedor_q;
  assign campeao_valido = campeao_valido_q;

endmodule
